regfile_dump: RTL and testbench

- Parametrised RISC-V integer register file with a built-in debug dump engine.
- Two combinational read ports and one write port, with x0 hardwired to zero.
- On request, an FSM streams every register out over a valid/ready channel as (index, data, last) beats. This replaces per-register monitor wiring in benches and gives the datapath a hardware trace path.
- Instantiated inside Datapath in place of the flat register array.

---
 rtl/regfile_pkg.sv | 25 ++
 rtl/dump_streamer.sv | 92 +++++++++
 rtl/regfile_dump.sv | 90 +++++++++
 tb/tb_regfile_dump.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register file with debug dump engine:
// default sizes, dump FSM state encoding and a clog2 helper.
package regfile_pkg;

  localparam int XLEN_DEFAULT     = 32;
  localparam int NUM_REGS_DEFAULT = 32;

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_STREAM = 1'b1;

  typedef enum logic {
    S_IDLE   = ST_IDLE,
    S_STREAM = ST_STREAM
  } dump_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((32'sd1 <<< r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dump_streamer.sv
// Dump engine: walks every register index once and presents it as
// (index, data, last) beats on a valid/ready channel.
module dump_streamer
  import regfile_pkg::*;
#(
  parameter  int XLEN     = XLEN_DEFAULT,
  parameter  int NUM_REGS = NUM_REGS_DEFAULT,
  localparam int ADDR_W   = clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dumpStart,
  input  logic              dumpReady,
  input  logic [XLEN-1:0]   rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              dumpBusy,
  output logic              dumpValid,
  output logic [ADDR_W-1:0] dumpIndex,
  output logic [XLEN-1:0]   dumpData,
  output logic              dumpLast
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE_IDX  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  dump_state_e       state_r;
  logic [ADDR_W-1:0] index_r;
  logic              valid_r;
  logic              last_r;
  logic [XLEN-1:0]   data_r;

  // Address of the beat loaded on the next edge: register 0 on start, else the successor.
  always_comb begin
    if (state_r == S_STREAM) begin
      rd_addr = index_r + ONE_IDX;
    end else begin
      rd_addr = ZERO_IDX;
    end
  end

  // Dump FSM with registered beat outputs; dumpStart only matters in idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= S_IDLE;
      index_r <= ZERO_IDX;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      data_r  <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (dumpStart) begin
            state_r <= S_STREAM;
            index_r <= ZERO_IDX;
            data_r  <= rd_data;
            valid_r <= 1'b1;
            last_r  <= 1'b0;
          end
        end
        S_STREAM: begin
          if (valid_r && dumpReady) begin
            if (last_r) begin
              state_r <= S_IDLE;
              index_r <= ZERO_IDX;
              valid_r <= 1'b0;
              last_r  <= 1'b0;
            end else begin
              index_r <= index_r + ONE_IDX;
              data_r  <= rd_data;
              last_r  <= ((index_r + ONE_IDX) == LAST_IDX);
            end
          end
        end
        default: begin
          state_r <= S_IDLE;
          index_r <= ZERO_IDX;
          valid_r <= 1'b0;
          last_r  <= 1'b0;
          data_r  <= {XLEN{1'b0}};
        end
      endcase
    end
  end

  assign dumpBusy  = (state_r == S_STREAM);
  assign dumpValid = valid_r;
  assign dumpIndex = index_r;
  assign dumpData  = data_r;
  assign dumpLast  = last_r;

endmodule

// File: rtl/regfile_dump.sv
// RISC-V integer register file (x0 hardwired to zero) with a debug dump port.
// Define REGFILE_DUMP_SNAPSHOT_EN to dump an atomic snapshot taken at start.
module regfile_dump
  import regfile_pkg::*;
#(
  parameter  int XLEN     = XLEN_DEFAULT,
  parameter  int NUM_REGS = NUM_REGS_DEFAULT,
  localparam int ADDR_W   = clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [XLEN-1:0]   writeData,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  output logic [XLEN-1:0]   readData1,
  output logic [XLEN-1:0]   readData2,
  input  logic              dumpStart,
  output logic              dumpBusy,
  output logic              dumpValid,
  input  logic              dumpReady,
  output logic [ADDR_W-1:0] dumpIndex,
  output logic [XLEN-1:0]   dumpData,
  output logic              dumpLast
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = {ADDR_W{1'b0}};

  logic [XLEN-1:0]   regs_r [NUM_REGS];
  logic [ADDR_W-1:0] rd_addr_s;
  logic [XLEN-1:0]   rd_data_s;

  // Register array write port; x0 is never written.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else if (regWrite && (writeReg != ZERO_IDX)) begin
      regs_r[writeReg] <= writeData;
    end
  end

  assign readData1 = (readReg1 == ZERO_IDX) ? {XLEN{1'b0}} : regs_r[readReg1];
  assign readData2 = (readReg2 == ZERO_IDX) ? {XLEN{1'b0}} : regs_r[readReg2];

`ifdef REGFILE_DUMP_SNAPSHOT_EN
  logic [XLEN-1:0] shadow_r [NUM_REGS];
  logic            snap_s;

  assign snap_s = dumpStart & ~dumpBusy;

  // Shadow copy taken on the start edge from pre-write contents.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_r[i] <= {XLEN{1'b0}};
      end
    end else if (snap_s) begin
      shadow_r[0] <= {XLEN{1'b0}};
      for (int i = 1; i < NUM_REGS; i++) begin
        shadow_r[i] <= regs_r[i];
      end
    end
  end

  assign rd_data_s = (rd_addr_s == ZERO_IDX) ? {XLEN{1'b0}} : shadow_r[rd_addr_s];
`else
  assign rd_data_s = (rd_addr_s == ZERO_IDX) ? {XLEN{1'b0}} : regs_r[rd_addr_s];
`endif

  dump_streamer #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS)
  ) u_streamer (
    .clock     (clock),
    .reset     (reset),
    .dumpStart (dumpStart),
    .dumpReady (dumpReady),
    .rd_data   (rd_data_s),
    .rd_addr   (rd_addr_s),
    .dumpBusy  (dumpBusy),
    .dumpValid (dumpValid),
    .dumpIndex (dumpIndex),
    .dumpData  (dumpData),
    .dumpLast  (dumpLast)
  );

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: table vectors, randomized read/write
// against an array model, and dump sequences (stall, mid-dump write, reset, restart).
module tb_regfile_dump;

  logic        clock;
  logic        reset;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic        dumpStart;
  logic        dumpBusy;
  logic        dumpValid;
  logic        dumpReady;
  logic [4:0]  dumpIndex;
  logic [31:0] dumpData;
  logic        dumpLast;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] mdl [32];

`ifdef REGFILE_DUMP_SNAPSHOT_EN
  localparam logic [31:0] BEAT10_EXP = 32'd10;
`else
  localparam logic [31:0] BEAT10_EXP = 32'hDEAD_BEEF;
`endif

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  regfile_dump dut (
    .clock     (clock),
    .reset     (reset),
    .regWrite  (regWrite),
    .writeReg  (writeReg),
    .writeData (writeData),
    .readReg1  (readReg1),
    .readReg2  (readReg2),
    .readData1 (readData1),
    .readData2 (readData2),
    .dumpStart (dumpStart),
    .dumpBusy  (dumpBusy),
    .dumpValid (dumpValid),
    .dumpReady (dumpReady),
    .dumpIndex (dumpIndex),
    .dumpData  (dumpData),
    .dumpLast  (dumpLast)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic model_write(input logic we, input logic [4:0] wa, input logic [31:0] wd);
    if (we && wa != 5'd0) mdl[wa] = wd;
  endtask

  // Runs one dump; mode 0 = ready high, 1 = ready 1,0,0 pattern, 2 = random ready.
  task automatic dump_run(input int mode, input bit wr10, input bit restart);
    logic [31:0] snap [32];
    logic [31:0] lv;
    int idx, beats, busy_cyc;
    bit rdy, wrote;
    idx = 0; beats = 0; busy_cyc = 0; wrote = 1'b0; lv = 32'h0; rdy = 1'b0;
    for (int i = 0; i < 32; i++) snap[i] = mdl[i];
    regWrite  = 1'b0;
    dumpStart = 1'b1;
    tick();
    dumpStart = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (!dumpBusy) break;
      busy_cyc++;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      dumpReady = rdy;
      chk("dump valid", 32'(dumpValid), 32'd1);
      chk("dump index", 32'(dumpIndex), 32'(idx));
      chk("dump data", dumpData, lv);
      chk("dump last", 32'(dumpLast), 32'((idx == 31) ? 1 : 0));
      if (wr10 && idx == 10) chk("beat10 value", dumpData, BEAT10_EXP);
      dumpStart = restart && (idx == 4 || idx == 31);
      if (wr10 && idx == 3 && !wrote) begin
        regWrite = 1'b1; writeReg = 5'd10; writeData = 32'hDEAD_BEEF; wrote = 1'b1;
      end
`ifdef REGFILE_DUMP_SNAPSHOT_EN
      if (rdy && idx < 31) lv = snap[idx+1];
`else
      if (rdy && idx < 31) lv = mdl[idx+1];
`endif
      model_write(regWrite, writeReg, writeData);
      tick();
      regWrite  = 1'b0;
      dumpStart = 1'b0;
      if (rdy) begin
        beats++;
        idx++;
      end
    end
    chk("beat count", 32'(beats), 32'd32);
    if (mode == 0) chk("busy cycles", 32'(busy_cyc), 32'd32);
    dumpReady = 1'b1;
    tick();
    tick();
    chk("idle busy after dump", 32'(dumpBusy), 32'd0);
    chk("idle valid after dump", 32'(dumpValid), 32'd0);
  endtask

  initial begin
    vec_t tbl [6];
    bit   hit7;
    tbl[0] = '{1'b1, 5'd5,  32'h0000_00AA, 5'd5,  5'd0,  32'h0000_00AA, 32'h0};
    tbl[1] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd5,  32'h0,          32'h0000_00AA};
    tbl[2] = '{1'b1, 5'd31, 32'h1234_5678, 5'd31, 5'd5,  32'h1234_5678,  32'h0000_00AA};
    tbl[3] = '{1'b0, 5'd31, 32'hFFFF_FFFF, 5'd31, 5'd0,  32'h1234_5678,  32'h0};
    tbl[4] = '{1'b1, 5'd1,  32'h0000_0001, 5'd1,  5'd31, 32'h0000_0001,  32'h1234_5678};
    tbl[5] = '{1'b1, 5'd5,  32'h0,          5'd5,  5'd1,  32'h0,          32'h0000_0001};

    reset = 1'b1; regWrite = 1'b0; writeReg = 5'd0; writeData = 32'h0;
    readReg1 = 5'd7; readReg2 = 5'd31; dumpStart = 1'b0; dumpReady = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    tick();
    tick();
    reset = 1'b0;
    chk("reset valid", 32'(dumpValid), 32'd0);
    chk("reset busy", 32'(dumpBusy), 32'd0);
    chk("reset last", 32'(dumpLast), 32'd0);
    chk("reset index", 32'(dumpIndex), 32'd0);
    chk("reset data", dumpData, 32'h0);
    chk("reset read1", readData1, 32'h0);
    chk("reset read2", readData2, 32'h0);

    for (int i = 0; i < 6; i++) begin
      regWrite = tbl[i].we; writeReg = tbl[i].wa; writeData = tbl[i].wd;
      tick();
      model_write(tbl[i].we, tbl[i].wa, tbl[i].wd);
      regWrite = 1'b0;
      readReg1 = tbl[i].r1; readReg2 = tbl[i].r2;
      #1;
      chk("table read1", readData1, tbl[i].e1);
      chk("table read2", readData2, tbl[i].e2);
    end

    // Same-cycle read of the register being written sees the old value.
    regWrite = 1'b1; writeReg = 5'd9; writeData = 32'h0000_0055; readReg1 = 5'd9;
    #1;
    chk("read before write edge", readData1, 32'h0);
    tick();
    model_write(1'b1, 5'd9, 32'h0000_0055);
    regWrite = 1'b0;
    chk("read after write edge", readData1, 32'h0000_0055);

    for (int i = 0; i < 300; i++) begin
      regWrite  = 1'($urandom_range(0, 1));
      writeReg  = 5'($urandom_range(0, 31));
      writeData = $urandom;
      readReg1  = 5'($urandom_range(0, 31));
      readReg2  = (i % 4 == 0) ? writeReg : 5'($urandom_range(0, 31));
      #1;
      chk("random read1", readData1, mdl[readReg1]);
      chk("random read2", readData2, mdl[readReg2]);
      tick();
      model_write(regWrite, writeReg, writeData);
    end
    regWrite = 1'b0;

    for (int i = 1; i < 32; i++) begin
      regWrite = 1'b1; writeReg = 5'(i); writeData = 32'(i);
      tick();
      model_write(1'b1, 5'(i), 32'(i));
    end
    regWrite = 1'b0;

    dump_run(0, 1'b0, 1'b0);
    dump_run(1, 1'b0, 1'b0);
    dump_run(2, 1'b1, 1'b0);
    dump_run(0, 1'b0, 1'b1);

    // Reset in the middle of a dump aborts it and clears the array.
    dumpReady = 1'b1; dumpStart = 1'b1;
    tick();
    dumpStart = 1'b0;
    hit7 = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (dumpValid && dumpIndex == 5'd7) begin
        hit7 = 1'b1;
        break;
      end
      tick();
    end
    chk("reached beat 7", 32'(hit7), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    chk("abort valid", 32'(dumpValid), 32'd0);
    chk("abort busy", 32'(dumpBusy), 32'd0);
    chk("abort last", 32'(dumpLast), 32'd0);
    tick();
    chk("abort stays idle", 32'(dumpValid), 32'd0);
    for (int i = 0; i < 32; i++) begin
      readReg1 = 5'(i); readReg2 = 5'(31 - i);
      #1;
      chk("cleared read1", readData1, 32'h0);
      chk("cleared read2", readData2, 32'h0);
    end
    dump_run(0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
